// File: rtl/uart_duplex_ctrl.sv
// Full-duplex 16x-oversampled UART: baud tick generator, TX/RX FIFOs, optional parity,
// 1/1.5/2 stop bits, sticky frame/parity/overrun flags and an internal loopback path.

module uart_duplex_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_i,
  input  logic [W-1:0] w_data_i,
  input  logic         rd_i,
  output logic [W-1:0] r_data_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          wr_en, rd_en;

  // A write into a full FIFO is taken only when a read frees a slot on the same edge.
  assign rd_en = rd_i & ~empty_q;
  assign wr_en = wr_i & (~full_q | rd_en);

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (wr_en) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_en) r_ptr_d = r_ptr_q + 1'b1;
    if (wr_en && !rd_en) begin
      empty_d = 1'b0;
      full_d  = (w_ptr_d == r_ptr_q);
    end else if (rd_en && !wr_en) begin
      full_d  = 1'b0;
      empty_d = (r_ptr_d == w_ptr_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[w_ptr_q] <= w_data_i;
  end

  assign r_data_o = empty_q ? '0 : mem_q[r_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
endmodule

module uart_duplex_ctrl #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     dvsr,
  input  logic            loopback,
  input  logic            rx,
  output logic            tx,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx_full,
  output logic            tx_empty,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  input  logic            clr_err,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun_err,
  output logic [2:0]      dbg_tx_state,
  output logic [2:0]      dbg_rx_state
);
  // Host handshake: a wr_uart pulse is accepted when tx_full is 0 (else dropped); a rd_uart
  // pulse pops the r_data head when rx_empty is 0 (else ignored). One word per clk.

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int TW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(15);
  localparam logic [TW-1:0] HALF_BIT  = TW'(7);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          ODD_BIT   = 1'(PARITY_ODD);

  // Baud generator; the divisor is captured at each wrap so changes never cut a period short.
  logic [10:0] baud_cnt_q, dvsr_q;
  logic        s_tick;

  assign s_tick = (baud_cnt_q == dvsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt_q <= '0;
      dvsr_q     <= '0;
    end else if (s_tick) begin
      baud_cnt_q <= '0;
      dvsr_q     <= dvsr;
    end else begin
      baud_cnt_q <= baud_cnt_q + 11'd1;
    end
  end

  logic [DBIT-1:0] tx_head;
  logic            tx_rd;

  uart_duplex_fifo #(.W(DBIT), .AW(ADDR_WIDTH)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (wr_uart),
    .w_data_i (w_data),
    .rd_i     (tx_rd),
    .r_data_o (tx_head),
    .full_o   (tx_full),
    .empty_o  (tx_empty)
  );

  state_t          tx_state_q;
  logic [TW-1:0]   tx_s_q;
  logic [NW-1:0]   tx_n_q;
  logic [DBIT-1:0] tx_b_q;
  logic            tx_par_q, tx_q;
  logic            tx_last_stop;

  // Popping on the final stop tick starts the next frame with no idle gap.
  assign tx_last_stop = (tx_state_q == S_STOP) && s_tick && (tx_s_q == STOP_LAST);
  assign tx_rd        = ~tx_empty & ((tx_state_q == S_IDLE) | tx_last_stop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_rd) begin
      tx_state_q <= S_START;
      tx_s_q     <= '0;
      tx_b_q     <= tx_head;
      tx_par_q   <= (^tx_head) ^ ODD_BIT;
      tx_q       <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: ;
        S_START: if (s_tick) begin
          if (tx_s_q == BIT_LAST) begin
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_state_q <= S_DATA;
            tx_q       <= tx_b_q[0];
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        S_DATA: if (s_tick) begin
          if (tx_s_q == BIT_LAST) begin
            tx_s_q <= '0;
            tx_b_q <= tx_b_q >> 1;
            if (tx_n_q == N_LAST) begin
              if (PARITY_EN != 0) begin
                tx_state_q <= S_PARITY;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_n_q <= tx_n_q + 1'b1;
              tx_q   <= tx_b_q[1];
            end
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        S_PARITY: if (s_tick) begin
          if (tx_s_q == BIT_LAST) begin
            tx_s_q     <= '0;
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        S_STOP: if (s_tick) begin
          if (tx_s_q == STOP_LAST) tx_state_q <= S_IDLE;
          else tx_s_q <= tx_s_q + 1'b1;
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign dbg_tx_state = tx_state_q;

  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= loopback ? tx_q : rx;
      sync2_q <= sync1_q;
    end
  end

  state_t          rx_state_q;
  logic [TW-1:0]   rx_s_q;
  logic [NW-1:0]   rx_n_q;
  logic [DBIT-1:0] rx_b_q, rx_word_q;
  logic            rx_par_bad_q, rx_done_q, rx_frame_flag_q, rx_par_flag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q      <= S_IDLE;
      rx_s_q          <= '0;
      rx_n_q          <= '0;
      rx_b_q          <= '0;
      rx_par_bad_q    <= 1'b0;
      rx_done_q       <= 1'b0;
      rx_word_q       <= '0;
      rx_frame_flag_q <= 1'b0;
      rx_par_flag_q   <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: if (!sync2_q) begin
          rx_state_q   <= S_START;
          rx_s_q       <= '0;
          rx_par_bad_q <= 1'b0;
        end
        S_START: if (s_tick) begin
          if (rx_s_q == HALF_BIT) begin
            if (sync2_q) rx_state_q <= S_IDLE;
            else begin
              rx_s_q     <= '0;
              rx_n_q     <= '0;
              rx_state_q <= S_DATA;
            end
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        S_DATA: if (s_tick) begin
          if (rx_s_q == BIT_LAST) begin
            rx_s_q <= '0;
            rx_b_q <= {sync2_q, rx_b_q[DBIT-1:1]};
            if (rx_n_q == N_LAST) rx_state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            else rx_n_q <= rx_n_q + 1'b1;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        S_PARITY: if (s_tick) begin
          if (rx_s_q == BIT_LAST) begin
            rx_s_q       <= '0;
            rx_par_bad_q <= sync2_q ^ (^rx_b_q) ^ ODD_BIT;
            rx_state_q   <= S_STOP;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        S_STOP: if (s_tick) begin
          if (rx_s_q == STOP_LAST) begin
            rx_state_q      <= S_IDLE;
            rx_done_q       <= 1'b1;
            rx_word_q       <= rx_b_q;
            rx_frame_flag_q <= ~sync2_q;
            rx_par_flag_q   <= rx_par_bad_q;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_rx_state = rx_state_q;

  uart_duplex_fifo #(.W(DBIT), .AW(ADDR_WIDTH)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (rx_done_q),
    .w_data_i (rx_word_q),
    .rd_i     (rd_uart),
    .r_data_o (r_data),
    .full_o   (rx_full),
    .empty_o  (rx_empty)
  );

  // A full FIFO still accepts the word if the host pops on the same edge.
  logic rx_drop;
  logic frame_err_q, parity_err_q, overrun_err_q;

  assign rx_drop = rx_done_q & rx_full & ~rd_uart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (rx_done_q && rx_frame_flag_q) frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
      if (rx_done_q && rx_par_flag_q) parity_err_q <= 1'b1;
      else if (clr_err) parity_err_q <= 1'b0;
      if (rx_drop) overrun_err_q <= 1'b1;
      else if (clr_err) overrun_err_q <= 1'b0;
    end
  end

  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
endmodule

// File: tb/tb_uart_duplex_ctrl.sv
// Directed bench for uart_duplex_ctrl (8 data bits, even parity, 1 stop, 4-deep FIFOs).
// Expected words flow through exp_q; serial bit levels are hand-derived from each byte.

module tb_uart_duplex_ctrl;
  localparam int DBIT = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [10:0]     dvsr = 11'd0;
  logic            loopback = 1'b1;
  logic            rx = 1'b1;
  logic            tx;
  logic            wr_uart = 1'b0;
  logic [DBIT-1:0] w_data = '0;
  logic            tx_full, tx_empty;
  logic            rd_uart = 1'b0;
  logic [DBIT-1:0] r_data;
  logic            rx_empty, rx_full;
  logic            clr_err = 1'b0;
  logic            frame_err, parity_err, overrun_err;
  logic [2:0]      dbg_tx_state, dbg_rx_state;

  int checks = 0;
  int errors = 0;
  logic [DBIT-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_duplex_ctrl #(
    .DBIT(DBIT), .SB_TICK(16), .ADDR_WIDTH(2), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .loopback     (loopback),
    .rx           (rx),
    .tx           (tx),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .rd_uart      (rd_uart),
    .r_data       (r_data),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .clr_err      (clr_err),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun_err  (overrun_err),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DBIT-1:0] d);
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = d;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int budget);
    int i = 0;
    while (rx_empty && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, rx_empty, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    logic [DBIT-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, r_data, e);
      check({tag, "_nonempty"}, rx_empty, 1'b0);
    end
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  // Pushes one byte with dvsr=0 and checks the serial waveform at each bit centre.
  task automatic tx_frame_check(input string tag, input logic [DBIT-1:0] d, input logic par);
    push(d);
    check({tag, "_tx_hold"}, tx, 1'b1);
    check({tag, "_txf_nonempty"}, tx_empty, 1'b0);
    cycles(1);
    check({tag, "_tx_fall"}, tx, 1'b0);
    check({tag, "_txf_popped"}, tx_empty, 1'b1);
    cycles(8);
    check({tag, "_start_mid"}, tx, 1'b0);
    for (int k = 0; k < DBIT; k++) begin
      cycles(16);
      check($sformatf("%s_bit%0d", tag, k), tx, d[k]);
    end
    cycles(16);
    check({tag, "_parity"}, tx, par);
    cycles(16);
    check({tag, "_stop"}, tx, 1'b1);
    exp_q.push_back(d);
  endtask

  task automatic send_frame(input logic [DBIT-1:0] d, input logic par, input logic stop);
    logic [DBIT+2:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < DBIT + 3; i++) begin
      rx = bits[i];
      cycles(16);
    end
    rx = 1'b1;
  endtask

  initial begin
    // reset state
    cycles(3);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_full", rx_full, 1'b0);
    check("rst_r_data", r_data, 8'h00);
    check("rst_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    check("rst_states", {dbg_tx_state, dbg_rx_state}, 6'd0);
    reset = 1'b0;
    cycles(2);

    // 1: loopback 0xA5, parity bit 0 (four ones)
    tx_frame_check("t1", 8'hA5, 1'b0);
    wait_rx("t1_rx_ready", 30);
    pop_check("t1_word");
    check("t1_rx_drained", rx_empty, 1'b1);
    check("t1_errs", {frame_err, parity_err}, 2'b00);

    // 2: loopback 0x07, parity bit 1 (three ones)
    cycles(5);
    tx_frame_check("t2", 8'h07, 1'b1);
    wait_rx("t2_rx_ready", 30);
    pop_check("t2_word");
    check("t2_parity_err", parity_err, 1'b0);

    // 3: external pin, bad parity then bad stop
    cycles(5);
    loopback = 1'b0;
    cycles(5);
    send_frame(8'h3C, 1'b1, 1'b1);
    exp_q.push_back(8'h3C);
    cycles(4);
    check("t3_parity_set", parity_err, 1'b1);
    check("t3_frame_clear", frame_err, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    exp_q.push_back(8'h81);
    cycles(40);
    check("t3_frame_set", frame_err, 1'b1);
    check("t3_parity_sticky", parity_err, 1'b1);
    check("t3_overrun", overrun_err, 1'b0);
    pop_check("t3_word0");
    pop_check("t3_word1");
    check("t3_drained", rx_empty, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t3_clr", {frame_err, parity_err}, 2'b00);

    // 5: short glitch on rx
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(40);
    check("t5_no_word", rx_empty, 1'b1);
    check("t5_no_errs", {frame_err, parity_err, overrun_err}, 3'b000);

    // 4: five words into a four-deep RX FIFO
    loopback = 1'b1;
    cycles(5);
    for (int i = 1; i <= 5; i++) push(8'(i));
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    begin
      int n = 0;
      while (!rx_full && n < 1200) begin
        @(negedge clk);
        n++;
      end
    end
    check("t4_rx_full", rx_full, 1'b1);
    check("t4_no_overrun_yet", overrun_err, 1'b0);
    cycles(250);
    check("t4_overrun", overrun_err, 1'b1);
    check("t4_still_full", rx_full, 1'b1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t4_word%0d", i));
    check("t4_drained", rx_empty, 1'b1);

    // 7: dvsr=1, fill the TX FIFO; sixth write is dropped
    dvsr = 11'd1;
    cycles(5);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("t7_not_full", tx_full, 1'b0);
    push(8'h55);
    check("t7_tx_full", tx_full, 1'b1);
    push(8'h66);
    check("t7_tx_full_hold", tx_full, 1'b1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 5; i++) begin
      wait_rx($sformatf("t7_rx_ready%0d", i), 800);
      pop_check($sformatf("t7_word%0d", i));
    end
    cycles(800);
    check("t7_sixth_dropped", rx_empty, 1'b1);
    check("t7_tx_idle", tx_empty, 1'b1);

    // 6: reset in the middle of a 0xFF frame
    dvsr = 11'd0;
    cycles(5);
    push(8'hFF);
    cycles(60);
    reset = 1'b1;
    #1;
    check("t6_tx_high", tx, 1'b1);
    check("t6_tx_empty", tx_empty, 1'b1);
    check("t6_rx_empty", rx_empty, 1'b1);
    check("t6_r_data", r_data, 8'h00);
    check("t6_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    cycles(3);
    push(8'h5A);
    exp_q.push_back(8'h5A);
    wait_rx("t6_rx_ready", 250);
    pop_check("t6_word");
    check("t6_errs_after", {frame_err, parity_err, overrun_err}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
